alu_seq: RTL and testbench
==========================

// Module: alu_seq
// PURPOSE
//  Parametrised multi-cycle ALU: next generation of the datapath ALU. Same 4-bit function encoding
//  plus REM, generic WIDTH, and iterative shift-add MUL / restoring DIV, REM instead of combinational * and /.
//  Registered outputs behind a valid/ready handshake; sits between register-file read and writeback,
//  and the control unit stalls on in_ready.
// PARAMETERS
//  WIDTH     16   operand/result width; power of two, >= 8
//  SHW       $clog2(WIDTH)   shift-amount width, taken from alu_a[SHW-1:0]; derived, not overridden
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      operation request
//  in_ready   out  1      block can accept; high only in IDLE
//  alu_func   in   4      operation code, sampled on accept
//  alu_a      in   WIDTH  source operand / shift amount
//  alu_b      in   WIDTH  destination operand
//  cin        in   1      carry in, ADD/SUB only
//  out_valid  out  1      one-cycle pulse: result and flags are new
//  alu_out    out  WIDTH  result, held until next out_valid
//  c,z,v,s    out  1 each carry, zero, overflow, sign; held with alu_out
//  dz         out  1      divide by zero on DIV/REM, held with alu_out
// BEHAVIOUR
//  Reset: state=IDLE, in_ready=1, out_valid=0, alu_out=0, c=z=v=s=dz=0; any operation in progress is
//    dropped with no out_valid. Reset wins over a simultaneous in_valid.
//  Accept = in_valid & in_ready. Operands, func, cin are latched; later input changes are ignored.
//  FSM: IDLE -(accept MUL)-> MUL; IDLE -(accept DIV/REM)-> DIV; other funcs stay IDLE.
//    MUL/DIV: WIDTH iterations by a cycle counter, then -> IDLE with out_valid.
//  Latency accept->out_valid: 1 cycle for single-cycle ops, WIDTH+1 for MUL/DIV/REM.
//  The out_valid cycle is an IDLE cycle, so a new accept there is legal (back-to-back throughput).
//  Funcs (a=alu_a, b=alu_b, n=a[SHW-1:0]):
//    0 ADD b+a+cin    1 SUB b-a-cin   2 AND   3 OR   4 XOR   5 SHL b<<n   6 SHR b>>n (logical)
//    7 NOT ~b   8 DIV b/a unsigned   9 MUL low WIDTH bits of b*a   A ROL b by n   B ROR b by n
//    C REM b%a unsigned   D-F result 0, all flags 0 except z=1
//  Flags, written only with out_valid:
//    z = (alu_out==0); s = alu_out[WIDTH-1]
//    c: ADD carry-out of the WIDTH+1-bit sum; SUB borrow (b < a+cin, unsigned WIDTH+1 compare);
//       SHL/SHR last bit shifted out, 0 when n=0; all other funcs 0
//    v: ADD a,b same sign and result sign differs; SUB a,b differing sign and result sign != b sign;
//       MUL high WIDTH bits of 2*WIDTH product nonzero; all other funcs 0
//    dz: DIV/REM with a==0 -> alu_out all ones (DIV) or b (REM), dz=1, still WIDTH+1 latency; else 0
//  Rotates/shifts use n only; upper bits of a are ignored (n=WIDTH impossible by width).
//  in_valid while busy is not accepted (in_ready=0); the requester holds it and may change it.
// STRUCTURE
//  Include file alu_seq_defs.vh: localparams for func codes 0-C and FSM state encodings (IDLE, MUL, DIV).
//  Sub-module alu_seq_iter: WIDTH-parametrised iterative MUL/DIV datapath
//    (start, op, a, b -> done, lo, hi/rem).
//  Top holds the FSM, single-cycle ops, flag logic and output registers.
// TESTING (WIDTH=16)
//  ADD a=0x0001 b=0xFFFF cin=0 -> out 0x0000, c=1 z=1 v=0 s=0, out_valid 1 cycle after accept.
//  SUB a=0x0001 b=0x8000 cin=0 -> out 0x7FFF, v=1 c=0 s=0. Then ROL a=4 b=0x1234 -> out 0x2341.
//  MUL a=0x0100 b=0x0100 -> out 0x0000, v=1 z=1, out_valid 17 cycles after accept, in_ready low throughout.
//  DIV a=7 b=100 -> 14; REM a=7 b=100 -> 2; DIV a=0 b=5 -> 0xFFFF, dz=1; each 17 cycles.
//  Back-to-back: accept MUL, then accept AND in the out_valid cycle -> AND result exactly 1 cycle later.
//  Reset asserted mid-DIV (cycle 8) -> no out_valid, all outputs 0, in_ready=1 the cycle after reset drops.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequential ALU: function codes, FSM state encoding
// and a helper that classifies multi-cycle operations.
// No ports; imported by alu_seq and alu_seq_iter.
package alu_seq_pkg;

  localparam logic [3:0] FUNC_ADD = 4'h0;
  localparam logic [3:0] FUNC_SUB = 4'h1;
  localparam logic [3:0] FUNC_AND = 4'h2;
  localparam logic [3:0] FUNC_OR  = 4'h3;
  localparam logic [3:0] FUNC_XOR = 4'h4;
  localparam logic [3:0] FUNC_SHL = 4'h5;
  localparam logic [3:0] FUNC_SHR = 4'h6;
  localparam logic [3:0] FUNC_NOT = 4'h7;
  localparam logic [3:0] FUNC_DIV = 4'h8;
  localparam logic [3:0] FUNC_MUL = 4'h9;
  localparam logic [3:0] FUNC_ROL = 4'hA;
  localparam logic [3:0] FUNC_ROR = 4'hB;
  localparam logic [3:0] FUNC_REM = 4'hC;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_e;

  // Operations that run on the iterative datapath instead of completing in one cycle.
  function automatic logic is_iter(input logic [3:0] f);
    return (f == FUNC_MUL) || (f == FUNC_DIV) || (f == FUNC_REM);
  endfunction

endpackage

// File: rtl/alu_seq_iter.sv
// Iterative shift-add multiplier / restoring divider, one bit per cycle.
// Latency: start plus WIDTH step cycles; lo/hi show the final step's result while done is high.
// Backpressure: none; the caller only starts it when idle and consumes the result in the done cycle.
// Ports: clk, rst (sync, active high), start, op_div (1=divide), a (divisor / multiplier),
//        b (dividend / multiplicand), done, lo (product low / quotient), hi (product high / remainder).
module alu_seq_iter
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  localparam int CW = $clog2(WIDTH);

  logic             busy_q, busy_d;
  logic             div_q, div_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [WIDTH-1:0] mul_add;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] step_hi, step_lo;

  always_comb begin
    // Multiply: {hi,lo} starts as {0,a}; add b into hi when lo[0] is set, then shift the
    // whole thing right with the add carry entering at the top.
    mul_add = lo_q[0] ? m_q : '0;
    mul_sum = {1'b0, hi_q} + {1'b0, mul_add};

    // Divide: hi is the partial remainder, lo shifts the dividend out and quotient bits in.
    // With a zero divisor every compare succeeds, giving an all-ones quotient and remainder b.
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, m_q};
    // When div_ge holds the true difference is below the divisor, so WIDTH bits suffice.
    div_diff  = div_shift[WIDTH-1:0] - m_q;

    if (div_q) begin
      step_hi = div_ge ? div_diff : div_shift[WIDTH-1:0];
      step_lo = {lo_q[WIDTH-2:0], div_ge};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
    end

    done = busy_q && (cnt_q == CW'(WIDTH - 1));
    lo   = step_lo;
    hi   = step_hi;

    busy_d = busy_q;
    div_d  = div_q;
    cnt_d  = cnt_q;
    m_d    = m_q;
    hi_d   = hi_q;
    lo_d   = lo_q;

    if (start) begin
      busy_d = 1'b1;
      div_d  = op_div;
      cnt_d  = '0;
      hi_d   = '0;
      lo_d   = op_div ? b : a;
      m_d    = op_div ? a : b;
    end else if (busy_q) begin
      cnt_d = cnt_q + 1'b1;
      hi_d  = step_hi;
      lo_d  = step_lo;
      if (done) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      div_q  <= 1'b0;
      cnt_q  <= '0;
      m_q    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      busy_q <= busy_d;
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      m_q    <= m_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU with registered result/flags behind a valid/ready handshake.
// Latency: 1 cycle for single-cycle ops, WIDTH+1 for MUL/DIV/REM; out_valid cycle may accept again.
// Backpressure: in_ready is high only in IDLE; requests while busy are left pending at the source.
// Ports: clk, rst (sync, active high), in_valid/in_ready, alu_func, alu_a, alu_b, cin,
//        out_valid (1-cycle pulse), alu_out, c, z, v, s, dz (all held until the next out_valid).
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  localparam int SHW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_func,
  input  logic [WIDTH-1:0] alu_a,
  input  logic [WIDTH-1:0] alu_b,
  input  logic             cin,
  output logic             out_valid,
  output logic [WIDTH-1:0] alu_out,
  output logic             c,
  output logic             z,
  output logic             v,
  output logic             s,
  output logic             dz
);

  state_e           state_q, state_d;
  logic [3:0]       func_q, func_d;
  logic             dzp_q, dzp_d;     // divide-by-zero seen at accept, reported at completion
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] alu_out_q, alu_out_d;
  logic             c_q, c_d, z_q, z_d, v_q, v_d, s_q, s_d, dz_q, dz_d;

  logic             it_start, it_done;
  logic [WIDTH-1:0] it_lo, it_hi;

  logic [SHW-1:0]   n, n_inv;
  logic [WIDTH:0]   sum_x, dif_x, shl_x, shr_x;
  logic [WIDTH-1:0] r_sc;
  logic             c_sc, v_sc;

  alu_seq_iter #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .rst    (rst),
    .start  (it_start),
    .op_div (func_d != FUNC_MUL),
    .a      (alu_a),
    .b      (alu_b),
    .done   (it_done),
    .lo     (it_lo),
    .hi     (it_hi)
  );

  // Single-cycle datapath, evaluated straight from the request inputs.
  always_comb begin
    n     = alu_a[SHW-1:0];
    n_inv = SHW'(0) - n;  // WIDTH-n modulo WIDTH; n=0 makes both rotate halves equal b
    sum_x = {1'b0, alu_b} + {1'b0, alu_a} + {{WIDTH{1'b0}}, cin};
    dif_x = {1'b0, alu_b} - {1'b0, alu_a} - {{WIDTH{1'b0}}, cin};
    // The extra bit catches the last bit shifted out; it stays 0 when n=0.
    shl_x = {1'b0, alu_b} << n;
    shr_x = {alu_b, 1'b0} >> n;

    r_sc = '0;
    c_sc = 1'b0;
    v_sc = 1'b0;
    case (alu_func)
      FUNC_ADD: begin
        r_sc = sum_x[WIDTH-1:0];
        c_sc = sum_x[WIDTH];
        v_sc = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) && (sum_x[WIDTH-1] != alu_b[WIDTH-1]);
      end
      FUNC_SUB: begin
        r_sc = dif_x[WIDTH-1:0];
        c_sc = dif_x[WIDTH];  // borrow: b < a+cin
        v_sc = (alu_a[WIDTH-1] != alu_b[WIDTH-1]) && (dif_x[WIDTH-1] != alu_b[WIDTH-1]);
      end
      FUNC_AND: r_sc = alu_b & alu_a;
      FUNC_OR:  r_sc = alu_b | alu_a;
      FUNC_XOR: r_sc = alu_b ^ alu_a;
      FUNC_SHL: begin
        r_sc = shl_x[WIDTH-1:0];
        c_sc = shl_x[WIDTH];
      end
      FUNC_SHR: begin
        r_sc = shr_x[WIDTH:1];
        c_sc = shr_x[0];
      end
      FUNC_NOT: r_sc = ~alu_b;
      FUNC_ROL: r_sc = (alu_b << n) | (alu_b >> n_inv);
      FUNC_ROR: r_sc = (alu_b >> n) | (alu_b << n_inv);
      default:  r_sc = '0;
    endcase
  end

  // FSM and output register next-state.
  always_comb begin
    state_d     = state_q;
    func_d      = func_q;
    dzp_d       = dzp_q;
    it_start    = 1'b0;
    out_valid_d = 1'b0;
    alu_out_d   = alu_out_q;
    c_d         = c_q;
    z_d         = z_q;
    v_d         = v_q;
    s_d         = s_q;
    dz_d        = dz_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (is_iter(alu_func)) begin
            it_start = 1'b1;
            func_d   = alu_func;
            dzp_d    = (alu_func != FUNC_MUL) && (alu_a == '0);
            state_d  = (alu_func == FUNC_MUL) ? ST_MUL : ST_DIV;
          end else begin
            out_valid_d = 1'b1;
            alu_out_d   = r_sc;
            c_d         = c_sc;
            v_d         = v_sc;
            dz_d        = 1'b0;
          end
        end
      end
      ST_MUL, ST_DIV: begin
        if (it_done) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b1;
          alu_out_d   = (func_q == FUNC_REM) ? it_hi : it_lo;
          c_d         = 1'b0;
          v_d         = (func_q == FUNC_MUL) && (it_hi != '0);
          dz_d        = dzp_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (out_valid_d) begin
      z_d = (alu_out_d == '0);
      s_d = alu_out_d[WIDTH-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      func_q      <= FUNC_ADD;
      dzp_q       <= 1'b0;
      out_valid_q <= 1'b0;
      alu_out_q   <= '0;
      c_q         <= 1'b0;
      z_q         <= 1'b0;
      v_q         <= 1'b0;
      s_q         <= 1'b0;
      dz_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      func_q      <= func_d;
      dzp_q       <= dzp_d;
      out_valid_q <= out_valid_d;
      alu_out_q   <= alu_out_d;
      c_q         <= c_d;
      z_q         <= z_d;
      v_q         <= v_d;
      s_q         <= s_d;
      dz_q        <= dz_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = out_valid_q;
  assign alu_out   = alu_out_q;
  assign c         = c_q;
  assign z         = z_q;
  assign v         = v_q;
  assign s         = s_q;
  assign dz        = dz_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=16): directed requests push expected results,
// a negedge monitor pops and compares result, flags and arrival cycle.
module tb_alu_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_func;
  logic [15:0] alu_a, alu_b;
  logic        cin;
  logic        out_valid;
  logic [15:0] alu_out;
  logic        c, z, v, s, dz;

  alu_seq #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_func  (alu_func),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .cin       (cin),
    .out_valid (out_valid),
    .alu_out   (alu_out),
    .c         (c),
    .z         (z),
    .v         (v),
    .s         (s),
    .dz        (dz)
  );

  typedef struct {
    string       name;
    logic [15:0] out;
    logic [4:0]  flg;  // {c,z,v,s,dz}
    int          due;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every out_valid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL spurious_out_valid: got out_valid=1 out=%h at cycle %0d, want no result", alu_out, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        n_tests++;
        if ({alu_out, c, z, v, s, dz} !== {mon_e.out, mon_e.flg}) begin
          n_fail++;
          $display("FAIL %s: got out=%h c%b z%b v%b s%b dz%b, want out=%h czvsd=%b",
                   mon_e.name, alu_out, c, z, v, s, dz, mon_e.out, mon_e.flg);
        end
        n_tests++;
        if (cyc != mon_e.due) begin
          n_fail++;
          $display("FAIL %s_latency: got result at cycle %0d, want cycle %0d", mon_e.name, cyc, mon_e.due);
        end
      end
    end
  end

  // Issue one request at a negedge once in_ready is seen, push its expectation,
  // then scramble the operands after the accepting edge to check they were latched.
  task automatic issue(input string name, input logic [3:0] f, input logic [15:0] a,
                       input logic [15:0] b, input logic ci, input logic [15:0] eo,
                       input logic [4:0] ef, input int lat);
    int   w;
    exp_t e;
    w = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && w < 60) begin
      @(negedge clk);
      w++;
    end
    if (in_ready !== 1'b1) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_ready_timeout: got in_ready=%b after %0d cycles, want 1", name, in_ready, w);
      return;
    end
    alu_func = f;
    alu_a    = a;
    alu_b    = b;
    cin      = ci;
    in_valid = 1'b1;
    e.name = name;
    e.out  = eo;
    e.flg  = ef;
    e.due  = cyc + lat;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    alu_func = 4'h2;
    alu_a    = 16'hDEAD;
    alu_b    = 16'hBEEF;
    cin      = 1'b1;
  endtask

  task automatic drain(input string name);
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: got %0d results outstanding, want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_idle_zero(input string name);
    n_tests++;
    if ({in_ready, out_valid, alu_out, c, z, v, s, dz} !== {1'b1, 1'b0, 16'h0000, 5'b00000}) begin
      n_fail++;
      $display("FAIL %s: got in_ready=%b out_valid=%b out=%h czvsd=%b%b%b%b%b, want 1 0 0000 00000",
               name, in_ready, out_valid, alu_out, c, z, v, s, dz);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got simulation still running, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bad;
    rst      = 1'b1;
    in_valid = 1'b0;
    alu_func = 4'h0;
    alu_a    = 16'h0;
    alu_b    = 16'h0;
    cin      = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_zero("reset_state");
    rst = 1'b0;

    // Single-cycle ops                        func  a        b        cin out      {c,z,v,s,dz} lat
    issue("add_carry_zero", 4'h0, 16'h0001, 16'hFFFF, 1'b0, 16'h0000, 5'b11000, 1);
    issue("sub_ovf",        4'h1, 16'h0001, 16'h8000, 1'b0, 16'h7FFF, 5'b00100, 1);
    issue("rol4",           4'hA, 16'h0004, 16'h1234, 1'b0, 16'h2341, 5'b00000, 1);
    issue("add_cin_ovf",    4'h0, 16'h7FFF, 16'h0001, 1'b1, 16'h8001, 5'b00110, 1);
    issue("sub_borrow",     4'h1, 16'h0002, 16'h0001, 1'b1, 16'hFFFE, 5'b10010, 1);
    issue("shl4",           4'h5, 16'h0004, 16'h1234, 1'b0, 16'h2340, 5'b10000, 1);
    issue("shr3_upper_a",   4'h6, 16'h0013, 16'h00F4, 1'b0, 16'h001E, 5'b10000, 1);
    issue("shl0",           4'h5, 16'h0010, 16'h8001, 1'b0, 16'h8001, 5'b00010, 1);
    issue("ror4",           4'hB, 16'h0004, 16'h1234, 1'b0, 16'h4123, 5'b00000, 1);
    issue("not",            4'h7, 16'h1111, 16'h00FF, 1'b0, 16'hFF00, 5'b00010, 1);
    issue("or",             4'h3, 16'hF000, 16'h000F, 1'b0, 16'hF00F, 5'b00010, 1);
    issue("xor_zero",       4'h4, 16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 5'b01000, 1);
    issue("func_e",         4'hE, 16'h1234, 16'h5678, 1'b1, 16'h0000, 5'b01000, 1);
    drain("single");

    // MUL with in_ready held low, then AND accepted in the out_valid cycle.
    issue("mul_ovf_zero",   4'h9, 16'h0100, 16'h0100, 1'b0, 16'h0000, 5'b01100, 17);
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (in_ready !== 1'b0) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL mul_busy_ready: got in_ready high in %0d busy cycles, want 0", bad);
    end
    issue("and_b2b",        4'h2, 16'h0F0F, 16'h3CFF, 1'b0, 16'h0C0F, 5'b00000, 1);
    drain("b2b");

    issue("mul_small",      4'h9, 16'h0012, 16'h0034, 1'b0, 16'h03A8, 5'b00000, 17);
    issue("mul_wrap",       4'h9, 16'h0003, 16'hFFFF, 1'b0, 16'hFFFD, 5'b00110, 17);
    issue("div",            4'h8, 16'h0007, 16'd100,  1'b0, 16'h000E, 5'b00000, 17);
    issue("rem",            4'hC, 16'h0007, 16'd100,  1'b0, 16'h0002, 5'b00000, 17);
    issue("div_by_zero",    4'h8, 16'h0000, 16'h0005, 1'b0, 16'hFFFF, 5'b00011, 17);
    issue("rem_by_zero",    4'hC, 16'h0000, 16'h0005, 1'b0, 16'h0005, 5'b00001, 17);
    drain("iter");

    // Reset in the 8th cycle of a DIV: the result must never appear.
    issue("div_aborted",    4'h8, 16'h0003, 16'd50,   1'b0, 16'h0010, 5'b00000, 17);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    void'(exp_q.pop_back());
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle_zero("after_mid_div_reset");
    repeat (25) @(negedge clk);

    issue("add_after_reset", 4'h0, 16'h0002, 16'h0003, 1'b0, 16'h0005, 5'b00000, 1);
    drain("final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
